// File: rtl/ncca_seq_mul_ctrl.sv
// Sequencing controller for the nibble-partitioned 8x8 approximate multiplier.
// One shared 4x4 sub-multiplier slot is stepped across LL, LH, HL, HH and accumulated.
module ncca_seq_mul_ctrl #(
    parameter bit SKIP_ZERO = 1'b1,
    parameter bit SAT       = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [3:0]  sub_a,
    output logic [3:0]  sub_b,
    output logic [1:0]  sub_sel,
    input  logic [7:0]  sub_prod,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] prod,
    output logic        ovf
);

    // state  | meaning
    // IDLE   | waiting for an operand pair, in_ready=1
    // MUL    | one issued quadrant per cycle, accumulating sub_prod
    // DONE   | result presented, waiting for out_ready
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  quad, quad_nxt;
    logic [7:0]  a_r, b_r;
    logic [16:0] acc;
    logic [16:0] pp_sh;
    logic [15:0] prod_r, prod_fin;
    logic        ovf_r;
    logic        accept;
    logic [3:0]  mask_in, mask_r;
    logic [2:0]  first_in, first_nxt;

    // Bit q set means quadrant q is issued to the shared slot.
    function automatic logic [3:0] issue_mask(input logic [7:0] x, input logic [7:0] y);
        logic [3:0] m;
        m[0] = !SKIP_ZERO || ((x[3:0] != 4'd0) && (y[3:0] != 4'd0));
        m[1] = !SKIP_ZERO || ((x[3:0] != 4'd0) && (y[7:4] != 4'd0));
        m[2] = !SKIP_ZERO || ((x[7:4] != 4'd0) && (y[3:0] != 4'd0));
        m[3] = !SKIP_ZERO || ((x[7:4] != 4'd0) && (y[7:4] != 4'd0));
        return m;
    endfunction

    // Returns {found, index} of the lowest issued quadrant at or above start.
    function automatic logic [2:0] first_from(input logic [3:0] m, input logic [2:0] start);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (m[i] && (3'(i) >= start)) begin
                r = {1'b1, 2'(i)};
            end
        end
        return r;
    endfunction

    assign mask_in   = issue_mask(a, b);
    assign mask_r    = issue_mask(a_r, b_r);
    assign first_in  = first_from(mask_in, 3'd0);
    assign first_nxt = first_from(mask_r, {1'b0, quad} + 3'd1);

    always_comb begin
        state_nxt = state;
        quad_nxt  = quad;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    accept = 1'b1;
                    if (first_in[2]) begin
                        state_nxt = S_MUL;
                        quad_nxt  = first_in[1:0];
                    end else begin
                        state_nxt = S_DONE;
                        quad_nxt  = 2'd0;
                    end
                end
            end
            S_MUL: begin
                if (first_nxt[2]) begin
                    quad_nxt = first_nxt[1:0];
                end else begin
                    state_nxt = S_DONE;
                    quad_nxt  = 2'd0;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                quad_nxt  = 2'd0;
            end
        endcase
    end

    always_comb begin
        case (quad)
            2'd0:    pp_sh = {9'd0, sub_prod};
            2'd3:    pp_sh = {1'b0, sub_prod, 8'd0};
            default: pp_sh = {5'd0, sub_prod, 4'd0};
        endcase
    end

    always_comb begin
        sub_a   = 4'd0;
        sub_b   = 4'd0;
        sub_sel = 2'd0;
        if (state == S_MUL) begin
            sub_a   = quad[1] ? a_r[7:4] : a_r[3:0];
            sub_b   = quad[0] ? b_r[7:4] : b_r[3:0];
            sub_sel = quad;
        end
    end

    assign prod_fin  = (SAT && acc[16]) ? 16'hFFFF : acc[15:0];
    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    // acc is frozen in DONE, so the live value is the result; afterwards the last result is held.
    assign prod      = (state == S_DONE) ? prod_fin : prod_r;
    assign ovf       = (state == S_DONE) ? acc[16]  : ovf_r;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            quad   <= 2'd0;
            a_r    <= 8'd0;
            b_r    <= 8'd0;
            acc    <= 17'd0;
            prod_r <= 16'd0;
            ovf_r  <= 1'b0;
        end else begin
            state <= state_nxt;
            quad  <= quad_nxt;
            if (accept) begin
                a_r <= a;
                b_r <= b;
                acc <= 17'd0;
            end else if (state == S_MUL) begin
                acc <= acc + pp_sh;
            end
            if (state == S_DONE) begin
                prod_r <= prod_fin;
                ovf_r  <= acc[16];
            end
        end
    end

endmodule

// File: tb/tb_ncca_seq_mul_ctrl.sv
// Bench for ncca_seq_mul_ctrl: instance 0 has SKIP_ZERO=0/SAT=1, instance 1 SKIP_ZERO=1/SAT=0.
// The sub-multiplier is modelled as exact 4x4 or forced to 8'hFF per instance.
module tb_ncca_seq_mul_ctrl;

    logic        clk;
    logic        rst_n     [2];
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [7:0]  a_s       [2];
    logic [7:0]  b_s       [2];
    logic [3:0]  sub_a     [2];
    logic [3:0]  sub_b     [2];
    logic [1:0]  sub_sel   [2];
    logic [7:0]  sub_prod  [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [15:0] prod      [2];
    logic        ovf       [2];
    logic        force_ff  [2];

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ncca_seq_mul_ctrl #(.SKIP_ZERO(g == 1), .SAT(g == 0)) u_dut (
            .clk(clk), .rst_n(rst_n[g]),
            .in_valid(in_valid[g]), .in_ready(in_ready[g]),
            .a(a_s[g]), .b(b_s[g]),
            .sub_a(sub_a[g]), .sub_b(sub_b[g]), .sub_sel(sub_sel[g]),
            .sub_prod(sub_prod[g]),
            .out_valid(out_valid[g]), .out_ready(out_ready[g]),
            .prod(prod[g]), .ovf(ovf[g])
        );
        assign sub_prod[g] = force_ff[g] ? 8'hFF : ({4'd0, sub_a[g]} * {4'd0, sub_b[g]});
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          inst;
        logic [7:0]  a;
        logic [7:0]  b;
        bit          frc;
        logic [15:0] prod;
        logic        ovf;
        int          lat;
        logic [3:0]  mask;
    } vec_t;

    typedef struct {
        logic [15:0] prod;
        logic        ovf;
        int          lat;
        logic [7:0]  seq;
        int          n;
    } exp_t;

    exp_t sbq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t make_exp(input logic [15:0] p, input logic o, input int l, input logic [3:0] m);
        exp_t e;
        e.prod = p; e.ovf = o; e.lat = l; e.seq = 8'd0; e.n = 0;
        for (int q = 0; q < 4; q++) begin
            if (m[q]) begin
                e.seq[2*e.n +: 2] = 2'(q);
                e.n++;
            end
        end
        return e;
    endfunction

    // Called just after the accept edge; walks the MUL cycles until out_valid or budget.
    task automatic wait_out(input int i, input logic [7:0] ta, input logic [7:0] tb_,
                            output int lat, output logic [7:0] seq, output int n,
                            output bit subok, output bit ok);
        lat = 1; seq = 8'd0; n = 0; subok = 1'b1; ok = 1'b0;
        while (lat <= 20) begin
            if (out_valid[i]) begin
                ok = 1'b1;
                break;
            end
            if (n < 4) seq[2*n +: 2] = sub_sel[i];
            n++;
            if (sub_a[i] !== (sub_sel[i][1] ? ta[7:4] : ta[3:0])) subok = 1'b0;
            if (sub_b[i] !== (sub_sel[i][0] ? tb_[7:4] : tb_[3:0])) subok = 1'b0;
            step();
            lat++;
        end
    endtask

    task automatic run_txn(input int i, input logic [7:0] ta, input logic [7:0] tb_, input bit frc,
                           input exp_t e, input string name);
        int lat, n;
        logic [7:0] seq;
        bit subok, ok;
        exp_t got;
        check({name, "_in_ready"}, 32'(in_ready[i]), 32'd1);
        a_s[i] = ta; b_s[i] = tb_; force_ff[i] = frc;
        out_ready[i] = 1'b1;
        in_valid[i] = 1'b1;
        step();
        in_valid[i] = 1'b0;
        sbq.push_back(e);
        wait_out(i, ta, tb_, lat, seq, n, subok, ok);
        got = sbq.pop_front();
        if (!ok) begin
            check({name, "_timeout"}, 32'd0, 32'd1);
            return;
        end
        check({name, "_prod"}, 32'(prod[i]), 32'(got.prod));
        check({name, "_ovf"}, 32'(ovf[i]), 32'(got.ovf));
        check({name, "_lat"}, 32'(lat), 32'(got.lat));
        check({name, "_nissue"}, 32'(n), 32'(got.n));
        check({name, "_selseq"}, 32'(seq), 32'(got.seq));
        check({name, "_subops"}, 32'(subok), 32'd1);
        step();
        check({name, "_vdrop"}, 32'(out_valid[i]), 32'd0);
        check({name, "_rdy_after"}, 32'(in_ready[i]), 32'd1);
        check({name, "_prodhold"}, 32'(prod[i]), 32'(got.prod));
    endtask

    vec_t tbl[10];

    initial begin
        int lat, n;
        logic [7:0] seq;
        bit subok, ok, hold_ok, rdy_ok, vld_ok;
        exp_t got;

        tbl[0] = '{0, 8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b0, 5, 4'hF};
        tbl[1] = '{0, 8'h11, 8'h11, 1'b1, 16'hFFFF, 1'b1, 5, 4'hF};
        tbl[2] = '{0, 8'h05, 8'h03, 1'b0, 16'h000F, 1'b0, 5, 4'hF};
        tbl[3] = '{0, 8'h00, 8'h7A, 1'b0, 16'h0000, 1'b0, 5, 4'hF};
        tbl[4] = '{1, 8'h05, 8'h03, 1'b0, 16'h000F, 1'b0, 2, 4'b0001};
        tbl[5] = '{1, 8'h00, 8'h7A, 1'b0, 16'h0000, 1'b0, 1, 4'b0000};
        tbl[6] = '{1, 8'h11, 8'h11, 1'b1, 16'h1FDF, 1'b1, 5, 4'hF};
        tbl[7] = '{1, 8'h12, 8'h34, 1'b0, 16'h03A8, 1'b0, 5, 4'hF};
        tbl[8] = '{1, 8'hA0, 8'h0B, 1'b0, 16'h06E0, 1'b0, 2, 4'b0100};
        tbl[9] = '{1, 8'hF0, 8'h0F, 1'b1, 16'h0FF0, 1'b0, 2, 4'b0100};

        for (int i = 0; i < 2; i++) begin
            rst_n[i] = 1'b0; in_valid[i] = 1'b0; out_ready[i] = 1'b0;
            a_s[i] = 8'd0; b_s[i] = 8'd0; force_ff[i] = 1'b0;
        end
        repeat (3) step();
        for (int i = 0; i < 2; i++) rst_n[i] = 1'b1;

        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst%0d_in_ready", i), 32'(in_ready[i]), 32'd1);
            check($sformatf("rst%0d_out_valid", i), 32'(out_valid[i]), 32'd0);
            check($sformatf("rst%0d_prod", i), 32'(prod[i]), 32'd0);
            check($sformatf("rst%0d_ovf", i), 32'(ovf[i]), 32'd0);
            check($sformatf("rst%0d_sub", i), 32'({sub_a[i], sub_b[i], sub_sel[i]}), 32'd0);
        end

        for (int k = 0; k < 10; k++) begin
            run_txn(tbl[k].inst, tbl[k].a, tbl[k].b, tbl[k].frc,
                    make_exp(tbl[k].prod, tbl[k].ovf, tbl[k].lat, tbl[k].mask),
                    $sformatf("vec%0d", k));
        end

        // Backpressure: result held for 6 cycles while a second operand is offered.
        a_s[1] = 8'h12; b_s[1] = 8'h34; force_ff[1] = 1'b0;
        out_ready[1] = 1'b0;
        in_valid[1] = 1'b1;
        step();
        in_valid[1] = 1'b0;
        sbq.push_back(make_exp(16'h03A8, 1'b0, 5, 4'hF));
        wait_out(1, 8'h12, 8'h34, lat, seq, n, subok, ok);
        got = sbq.pop_front();
        check("bp_valid", 32'(ok), 32'd1);
        check("bp_prod", 32'(prod[1]), 32'(got.prod));
        a_s[1] = 8'h05; b_s[1] = 8'h03;
        in_valid[1] = 1'b1;
        hold_ok = 1'b1; rdy_ok = 1'b1; vld_ok = 1'b1;
        repeat (6) begin
            step();
            if (prod[1] !== 16'h03A8) hold_ok = 1'b0;
            if (in_ready[1] !== 1'b0) rdy_ok = 1'b0;
            if (out_valid[1] !== 1'b1) vld_ok = 1'b0;
        end
        check("bp_hold", 32'(hold_ok), 32'd1);
        check("bp_rdy_low", 32'(rdy_ok), 32'd1);
        check("bp_valid_held", 32'(vld_ok), 32'd1);
        out_ready[1] = 1'b1;
        step();
        check("bp_release_valid", 32'(out_valid[1]), 32'd0);
        check("bp_release_rdy", 32'(in_ready[1]), 32'd1);
        check("bp_release_prod", 32'(prod[1]), 32'h03A8);
        step();
        in_valid[1] = 1'b0;
        sbq.push_back(make_exp(16'h000F, 1'b0, 2, 4'b0001));
        wait_out(1, 8'h05, 8'h03, lat, seq, n, subok, ok);
        got = sbq.pop_front();
        check("bp_next_valid", 32'(ok), 32'd1);
        check("bp_next_prod", 32'(prod[1]), 32'(got.prod));
        check("bp_next_lat", 32'(lat), 32'(got.lat));
        step();

        // Reset during the LH cycle discards the operation.
        a_s[1] = 8'hFF; b_s[1] = 8'hFF;
        in_valid[1] = 1'b1;
        step();
        in_valid[1] = 1'b0;
        check("mid_sel_ll", 32'(sub_sel[1]), 32'd0);
        step();
        check("mid_sel_lh", 32'(sub_sel[1]), 32'd1);
        rst_n[1] = 1'b0;
        step();
        rst_n[1] = 1'b1;
        check("mid_in_ready", 32'(in_ready[1]), 32'd1);
        check("mid_out_valid", 32'(out_valid[1]), 32'd0);
        check("mid_prod", 32'(prod[1]), 32'd0);
        check("mid_ovf", 32'(ovf[1]), 32'd0);
        check("mid_sub", 32'({sub_a[1], sub_b[1], sub_sel[1]}), 32'd0);
        vld_ok = 1'b1;
        repeat (4) begin
            step();
            if (out_valid[1] !== 1'b0) vld_ok = 1'b0;
        end
        check("mid_no_result", 32'(vld_ok), 32'd1);
        run_txn(1, 8'h12, 8'h34, 1'b0, make_exp(16'h03A8, 1'b0, 5, 4'hF), "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
